// File: rtl/uart_reg_responder.sv
// Register-access responder behind the uart_top FIFOs: 'W' addr data -> ACK, 'R' addr -> value, errors -> NAK.
// Optional feature macro: UART_REG_CHECKSUM_EN (trailing XOR checksum byte on W/R frames).
module uart_reg_responder #(
  parameter int unsigned NREGS          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic               i_sys_clk,
  input  logic               i_sys_rst_n,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  input  logic               i_rx_empty,
  output logic               o_rx_read_en,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_write_en,
  input  logic               i_tx_full,
  output logic [NREGS*8-1:0] o_regs,
  output logic               o_busy,
  output logic               o_timeout
);

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;
  localparam int unsigned CW   = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_ADDR = 3'd1,
    GET_DATA = 3'd2,
`ifdef UART_REG_CHECKSUM_EN
    GET_CSUM = 3'd3,
`endif
    EXEC     = 3'd4,
    SEND     = 3'd5
  } state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      idle_cnt;
  logic [7:0]         cmd_q, addr_q, data_q, reply_q;
  logic [7:0]         rd_val, reply_c;
  logic [NREGS*8-1:0] regs;
  logic               rx_phase, get_phase, pop, tmo, wr_c, timeout_q;
  logic               cmd_ok, addr_ok, csum_ok;
  logic               unused_empty;
`ifdef UART_REG_CHECKSUM_EN
  logic [7:0]         csum_q;
`endif

  // The FIFO valid flag alone governs popping.
  assign unused_empty = i_rx_empty;

  // Read mux over the flat register vector.
  always_comb begin
    rd_val = 8'h00;
    for (int k = 0; k < int'(NREGS); k++) begin
      if (addr_q == 8'(k)) rd_val = regs[k*8 +: 8];
    end
  end

  // Next state, pop/timeout decode and EXEC reply selection.
  always_comb begin
    state_nxt = state;
    rx_phase  = 1'b0;
    get_phase = 1'b0;
    wr_c      = 1'b0;
    reply_c   = NAK;
    cmd_ok    = (cmd_q == CMD_W) || (cmd_q == CMD_R);
    addr_ok   = {1'b0, addr_q} < 9'(NREGS);
`ifdef UART_REG_CHECKSUM_EN
    csum_ok   = csum_q == (cmd_q ^ addr_q ^ ((cmd_q == CMD_W) ? data_q : 8'h00));
`else
    csum_ok   = 1'b1;
`endif
    case (state)
      IDLE: begin
        rx_phase = 1'b1;
        if (i_rx_valid)
          state_nxt = (i_rx_data == CMD_W || i_rx_data == CMD_R) ? GET_ADDR : EXEC;
      end
      GET_ADDR: begin
        rx_phase  = 1'b1;
        get_phase = 1'b1;
`ifdef UART_REG_CHECKSUM_EN
        if (i_rx_valid) state_nxt = (cmd_q == CMD_W) ? GET_DATA : GET_CSUM;
`else
        if (i_rx_valid) state_nxt = (cmd_q == CMD_W) ? GET_DATA : EXEC;
`endif
      end
      GET_DATA: begin
        rx_phase  = 1'b1;
        get_phase = 1'b1;
`ifdef UART_REG_CHECKSUM_EN
        if (i_rx_valid) state_nxt = GET_CSUM;
`else
        if (i_rx_valid) state_nxt = EXEC;
`endif
      end
`ifdef UART_REG_CHECKSUM_EN
      GET_CSUM: begin
        rx_phase  = 1'b1;
        get_phase = 1'b1;
        if (i_rx_valid) state_nxt = EXEC;
      end
`endif
      EXEC: begin
        state_nxt = SEND;
        if (cmd_ok && addr_ok && csum_ok) begin
          wr_c    = (cmd_q == CMD_W);
          reply_c = (cmd_q == CMD_W) ? ACK : rd_val;
        end
      end
      SEND: begin
        if (!i_tx_full) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    pop = rx_phase && i_rx_valid;
    tmo = get_phase && !i_rx_valid && (idle_cnt == CW'(TIMEOUT_CYCLES - 1));
    if (tmo) state_nxt = IDLE;
  end

  // State, frame capture, idle counter and register file.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state     <= IDLE;
      idle_cnt  <= '0;
      cmd_q     <= 8'h00;
      addr_q    <= 8'h00;
      data_q    <= 8'h00;
      reply_q   <= 8'h00;
      timeout_q <= 1'b0;
      regs      <= '0;
`ifdef UART_REG_CHECKSUM_EN
      csum_q    <= 8'h00;
`endif
    end else begin
      state     <= state_nxt;
      timeout_q <= tmo;
      idle_cnt  <= (get_phase && !pop) ? idle_cnt + CW'(1) : '0;
      if (pop) begin
        case (state)
          IDLE:     cmd_q  <= i_rx_data;
          GET_ADDR: addr_q <= i_rx_data;
          GET_DATA: data_q <= i_rx_data;
`ifdef UART_REG_CHECKSUM_EN
          GET_CSUM: csum_q <= i_rx_data;
`endif
          default: ;
        endcase
      end
      if (state == EXEC) reply_q <= reply_c;
      if (wr_c) begin
        for (int k = 0; k < int'(NREGS); k++) begin
          if (addr_q == 8'(k)) regs[k*8 +: 8] <= data_q;
        end
      end
    end
  end

  assign o_rx_read_en  = pop;
  assign o_tx_write_en = (state == SEND) && !i_tx_full;
  assign o_tx_data     = reply_q;
  assign o_busy        = (state != IDLE);
  assign o_timeout     = timeout_q;
  assign o_regs        = regs;

endmodule

// File: tb/tb_uart_reg_responder.sv
// Self-checking bench for uart_reg_responder: FIFO models around the DUT, vector table plus corner sequences.
module tb_uart_reg_responder;

  localparam int NREGS = 16;
  localparam int TMO   = 50;

  logic             i_sys_clk = 1'b0;
  logic             i_sys_rst_n = 1'b0;
  logic [7:0]       i_rx_data = 8'h00;
  logic             i_rx_valid = 1'b0;
  logic             i_rx_empty = 1'b1;
  logic             i_tx_full = 1'b0;
  logic             o_rx_read_en, o_tx_write_en, o_busy, o_timeout;
  logic [7:0]       o_tx_data;
  logic [NREGS*8-1:0] o_regs;

  uart_reg_responder #(.NREGS(NREGS), .TIMEOUT_CYCLES(TMO)) dut (
    .i_sys_clk(i_sys_clk), .i_sys_rst_n(i_sys_rst_n),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .i_rx_empty(i_rx_empty),
    .o_rx_read_en(o_rx_read_en), .o_tx_data(o_tx_data), .o_tx_write_en(o_tx_write_en),
    .i_tx_full(i_tx_full), .o_regs(o_regs), .o_busy(o_busy), .o_timeout(o_timeout)
  );

  always #5 i_sys_clk = ~i_sys_clk;

  logic [7:0] rx_q[$];
  logic [7:0] tx_log[$];
  int         tx_cyc[$];
  int         pop_cyc[$];
  int         cyc = 0;
  int         tmo_cnt = 0;
  int         tmo_cyc = -1;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] mregs [NREGS];

  // Sample DUT handshakes just before they take effect.
  always @(posedge i_sys_clk) begin
    if (o_rx_read_en && rx_q.size() != 0) begin
      void'(rx_q.pop_front());
      pop_cyc.push_back(cyc);
    end
    if (o_tx_write_en) begin
      tx_log.push_back(o_tx_data);
      tx_cyc.push_back(cyc);
    end
    if (o_timeout) begin
      tmo_cnt++;
      tmo_cyc = cyc;
    end
    cyc++;
  end

  // First-word-fall-through RX FIFO head.
  always @(negedge i_sys_clk) begin
    i_rx_valid = (rx_q.size() != 0);
    i_rx_empty = (rx_q.size() == 0);
    i_rx_data  = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NREGS*8-1:0] model_regs();
    logic [NREGS*8-1:0] v;
    for (int k = 0; k < NREGS; k++) v[k*8 +: 8] = mregs[k];
    return v;
  endfunction

  function automatic logic [7:0] tx_at(input int i);
    if (i < tx_log.size()) return tx_log[i];
    return 8'hxx;
  endfunction

  function automatic int tx_cyc_at(input int i);
    if (i < tx_cyc.size()) return tx_cyc[i];
    return -1000;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_sys_clk);
      #1;
    end
  endtask

  task automatic wait_tx(input int n, input int budget, input string name);
    int k = 0;
    while (tx_log.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    check(name, 128'(tx_log.size() >= n), 128'(1));
  endtask

  task automatic wait_rx_drained(input int budget);
    int k = 0;
    while (rx_q.size() != 0 && k < budget) begin
      tick(1);
      k++;
    end
    check("rx_drain", 128'(rx_q.size()), 128'(0));
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input int nb);
    rx_q.push_back(b0);
    if (nb > 1) rx_q.push_back(b1);
    if (nb > 2) rx_q.push_back(b2);
`ifdef UART_REG_CHECKSUM_EN
    if (b0 == 8'h57 || b0 == 8'h52) rx_q.push_back(b0 ^ b1 ^ ((nb > 2) ? b2 : 8'h00));
`endif
  endtask

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         nb;
    logic [7:0] rep;
    bit         wr;
    int         idx;
    logic [7:0] val;
  } vec_t;

  vec_t vt [13];

  initial begin
    int n0, p, d;
    vt[0]  = '{8'h57, 8'h03, 8'hA5, 3, 8'h06, 1'b1, 3,  8'hA5};
    vt[1]  = '{8'h52, 8'h03, 8'h00, 2, 8'hA5, 1'b0, 0,  8'h00};
    vt[2]  = '{8'h41, 8'h00, 8'h00, 1, 8'h15, 1'b0, 0,  8'h00};
    vt[3]  = '{8'h57, 8'h10, 8'hFF, 3, 8'h15, 1'b0, 0,  8'h00};
    vt[4]  = '{8'h57, 8'h0F, 8'h3C, 3, 8'h06, 1'b1, 15, 8'h3C};
    vt[5]  = '{8'h52, 8'h0F, 8'h00, 2, 8'h3C, 1'b0, 0,  8'h00};
    vt[6]  = '{8'h52, 8'h10, 8'h00, 2, 8'h15, 1'b0, 0,  8'h00};
    vt[7]  = '{8'h57, 8'h00, 8'h11, 3, 8'h06, 1'b1, 0,  8'h11};
    vt[8]  = '{8'h52, 8'h00, 8'h00, 2, 8'h11, 1'b0, 0,  8'h00};
    vt[9]  = '{8'h52, 8'h05, 8'h00, 2, 8'h00, 1'b0, 0,  8'h00};
    vt[10] = '{8'h57, 8'hFF, 8'h00, 3, 8'h15, 1'b0, 0,  8'h00};
    vt[11] = '{8'h52, 8'h57, 8'h00, 2, 8'h15, 1'b0, 0,  8'h00};
    vt[12] = '{8'h00, 8'h00, 8'h00, 1, 8'h15, 1'b0, 0,  8'h00};
    for (int k = 0; k < NREGS; k++) mregs[k] = 8'h00;

    // Reset state.
    #1;
    check("rst_read_en", 128'(o_rx_read_en), 128'(0));
    check("rst_write_en", 128'(o_tx_write_en), 128'(0));
    check("rst_busy", 128'(o_busy), 128'(0));
    check("rst_timeout", 128'(o_timeout), 128'(0));
    check("rst_tx_data", 128'(o_tx_data), 128'(0));
    check("rst_regs", 128'(o_regs), 128'(0));
    tick(3);
    @(negedge i_sys_clk);
    i_sys_rst_n = 1'b1;
    tick(2);

    // Table-driven frames.
    for (int i = 0; i < 13; i++) begin
      n0 = tx_log.size();
      send_frame(vt[i].b0, vt[i].b1, vt[i].b2, vt[i].nb);
      wait_tx(n0 + 1, 40, $sformatf("vec%0d_reply_seen", i));
      tick(3);
      check($sformatf("vec%0d_reply", i), 128'(tx_at(n0)), 128'(vt[i].rep));
      check($sformatf("vec%0d_push_count", i), 128'(tx_log.size()), 128'(n0 + 1));
      if (vt[i].wr) mregs[vt[i].idx] = vt[i].val;
      check($sformatf("vec%0d_regs", i), 128'(o_regs), 128'(model_regs()));
    end

    // Reply latency: first push exactly two cycles after the last frame byte is popped.
    n0 = tx_log.size();
    send_frame(8'h52, 8'h03, 8'h00, 2);
    wait_tx(n0 + 1, 40, "lat_reply_seen");
    check("lat_reply", 128'(tx_at(n0)), 128'(8'hA5));
    check("lat_cycles", 128'(tx_cyc_at(n0) - pop_cyc[$]), 128'(2));
    tick(2);

    // TX backpressure: no push while full, one push when it drops, queued byte waits.
    n0 = tx_log.size();
    i_tx_full = 1'b1;
    send_frame(8'h52, 8'h03, 8'h00, 2);
    rx_q.push_back(8'h41);
    tick(20);
    check("bp_no_push", 128'(tx_log.size()), 128'(n0));
    check("bp_write_en_low", 128'(o_tx_write_en), 128'(0));
    check("bp_rx_held", 128'(rx_q.size()), 128'(1));
    d = cyc;
    i_tx_full = 1'b0;
    wait_tx(n0 + 1, 10, "bp_reply_seen");
    check("bp_reply", 128'(tx_at(n0)), 128'(8'hA5));
    check("bp_push_cycle", 128'(tx_cyc_at(n0)), 128'(d));
    wait_tx(n0 + 2, 20, "bp_next_seen");
    check("bp_next_reply", 128'(tx_at(n0 + 1)), 128'(8'h15));
    check("bp_next_pop_cycle", 128'(pop_cyc[$]), 128'(tx_cyc_at(n0) + 1));
    tick(3);
    check("bp_push_count", 128'(tx_log.size()), 128'(n0 + 2));

    // Timeout on a partial frame.
    n0 = tx_log.size();
    p = tmo_cnt;
    rx_q.push_back(8'h57);
    rx_q.push_back(8'h03);
    wait_rx_drained(10);
    d = pop_cyc[$];
    for (int k = 0; k < 80 && tmo_cnt == p; k++) tick(1);
    tick(5);
    check("tmo_pulses", 128'(tmo_cnt), 128'(p + 1));
    check("tmo_delay_in_range", 128'((tmo_cyc - d) >= TMO && (tmo_cyc - d) <= TMO + 2), 128'(1));
    check("tmo_no_push", 128'(tx_log.size()), 128'(n0));
    check("tmo_regs", 128'(o_regs), 128'(model_regs()));
    check("tmo_idle", 128'(o_busy), 128'(0));
    send_frame(8'h52, 8'h03, 8'h00, 2);
    wait_tx(n0 + 1, 40, "tmo_after_seen");
    check("tmo_after_reply", 128'(tx_at(n0)), 128'(8'hA5));
    tick(3);

    // Reset mid-frame clears registers and returns to IDLE.
    rx_q.push_back(8'h57);
    rx_q.push_back(8'h05);
    wait_rx_drained(10);
    tick(1);
    check("midrst_busy_before", 128'(o_busy), 128'(1));
    i_sys_rst_n = 1'b0;
    #1;
    check("midrst_regs", 128'(o_regs), 128'(0));
    check("midrst_busy", 128'(o_busy), 128'(0));
    check("midrst_tx_data", 128'(o_tx_data), 128'(0));
    tick(2);
    @(negedge i_sys_clk);
    i_sys_rst_n = 1'b1;
    for (int k = 0; k < NREGS; k++) mregs[k] = 8'h00;
    tick(2);
    n0 = tx_log.size();
    send_frame(8'h52, 8'h03, 8'h00, 2);
    wait_tx(n0 + 1, 40, "midrst_after_seen");
    check("midrst_after_reply", 128'(tx_at(n0)), 128'(8'h00));
    tick(3);

`ifdef UART_REG_CHECKSUM_EN
    // Bad checksum: NAK and no write.
    n0 = tx_log.size();
    rx_q.push_back(8'h57);
    rx_q.push_back(8'h03);
    rx_q.push_back(8'hA5);
    rx_q.push_back(8'hF0);
    wait_tx(n0 + 1, 40, "csum_bad_seen");
    tick(3);
    check("csum_bad_reply", 128'(tx_at(n0)), 128'(8'h15));
    check("csum_bad_regs", 128'(o_regs), 128'(model_regs()));
    n0 = tx_log.size();
    rx_q.push_back(8'h57);
    rx_q.push_back(8'h03);
    rx_q.push_back(8'hA5);
    rx_q.push_back(8'hF1);
    wait_tx(n0 + 1, 40, "csum_good_seen");
    tick(3);
    mregs[3] = 8'hA5;
    check("csum_good_reply", 128'(tx_at(n0)), 128'(8'h06));
    check("csum_good_regs", 128'(o_regs), 128'(model_regs()));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
